// File: rtl/cyc_ctl_gen.sv
// rtl/cyc_ctl_gen.sv - ND120 microcycle generator producing TERM_n and the inverted phase count CC_n
//
// Ports:
//   sysclk, sys_rst_n      clock, asynchronous active-low reset
//   RUN                    enable cycling (0 parks in IDLE after the current cycle)
//   CSDELAY, SHORT_n,      next-cycle length controls, sampled on the TERM clock
//   SLOW_n                 (or on the IDLE exit clock)
//   MREQ_n, IORQ_n         bus request, sampled in phase 0
//   RDY                    bus ready handshake, sticky from phase 0
//   TRAP_n                 level-sensitive abort, forces TERM on the next clock
//   TERM_n                 low for one clock in the last phase of each cycle
//   CC_n                   inverted phase count
//   CX_n                   low during CSDELAY-added phases and wait phases
//   WAIT_ACT               high while held waiting for RDY
//   TMO                    one-clock pulse when the wait timeout expires
//   LEN                    current cycle length
module cyc_ctl_gen #(
  parameter int CC_W       = 4,
  parameter int DLY_W      = 2,
  parameter int BASE_LEN   = 4,
  parameter int SHORT_LEN  = 3,
  parameter int SLOW_EXTRA = 2,
  parameter int TMO_W      = 8
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             RUN,
  input  logic [DLY_W-1:0] CSDELAY,
  input  logic             SHORT_n,
  input  logic             SLOW_n,
  input  logic             MREQ_n,
  input  logic             IORQ_n,
  input  logic             RDY,
  input  logic             TRAP_n,
  output logic             TERM_n,
  output logic [CC_W-1:0]  CC_n,
  output logic             CX_n,
  output logic             WAIT_ACT,
  output logic             TMO,
  output logic [CC_W-1:0]  LEN
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_TERM = 2'd3;

  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_PRE = TMO_MAX - TMO_W'(1);

  logic [1:0]       r_state;
  logic [CC_W-1:0]  r_phase;
  logic [CC_W-1:0]  r_len;
  logic [CC_W-1:0]  r_bs;       // base + slow part; phases at or above it are delay phases
  logic             r_req;
  logic             r_rdy;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo;
  logic             r_term_n;
  logic [CC_W-1:0]  r_cc_n;
  logic             r_cx_n;
  logic             r_wait_act;

  logic [CC_W-1:0]  w_bs_new;
  logic [CC_W-1:0]  w_len_new;
  logic             w_load;
  logic [CC_W-1:0]  w_bs_nxt;
  logic [1:0]       w_state_nxt;
  logic [CC_W-1:0]  w_phase_nxt;
  logic [TMO_W-1:0] w_cnt_nxt;
  logic             w_tmo_nxt;
  logic             w_ext_nxt;

  assign w_bs_new  = (SHORT_n ? CC_W'(BASE_LEN) : CC_W'(SHORT_LEN))
                   + (SLOW_n ? '0 : CC_W'(SLOW_EXTRA));
  assign w_len_new = w_bs_new + CC_W'(CSDELAY);

  // The length is re-evaluated only when a new cycle is about to begin.
  assign w_load   = (r_state == S_TERM) || ((r_state == S_IDLE) && RUN);
  assign w_bs_nxt = w_load ? w_bs_new : r_bs;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = '0;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (RUN) begin
          w_state_nxt = S_RUN;
          w_phase_nxt = '0;
        end
      end
      S_RUN: begin
        if (!TRAP_n) begin
          w_state_nxt = S_TERM;
          w_phase_nxt = r_len - CC_W'(1);
        end else if (r_phase == r_len - CC_W'(2)) begin
          // RDY on this very clock still counts as an early ready.
          if (r_req && !(r_rdy || RDY)) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_TERM;
            w_phase_nxt = r_len - CC_W'(1);
          end
        end else begin
          w_phase_nxt = r_phase + CC_W'(1);
        end
      end
      S_WAIT: begin
        if (!TRAP_n || RDY || (r_tmo_cnt == TMO_MAX)) begin
          w_state_nxt = S_TERM;
          w_phase_nxt = r_len - CC_W'(1);
        end else begin
          w_cnt_nxt = r_tmo_cnt + TMO_W'(1);
          // TMO is shown during the final wait clock, before the forced TERM.
          w_tmo_nxt = (r_tmo_cnt == TMO_PRE);
        end
      end
      default: begin
        w_phase_nxt = '0;
        w_state_nxt = RUN ? S_RUN : S_IDLE;
      end
    endcase
  end

  assign w_ext_nxt = (w_state_nxt == S_WAIT)
                   || (((w_state_nxt == S_RUN) || (w_state_nxt == S_TERM))
                       && (w_phase_nxt >= w_bs_nxt));

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_len      <= CC_W'(BASE_LEN);
      r_bs       <= CC_W'(BASE_LEN);
      r_req      <= 1'b0;
      r_rdy      <= 1'b0;
      r_tmo_cnt  <= '0;
      r_tmo      <= 1'b0;
      r_term_n   <= 1'b1;
      r_cc_n     <= '1;
      r_cx_n     <= 1'b1;
      r_wait_act <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_tmo_cnt <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      if (w_load) begin
        r_len <= w_len_new;
        r_bs  <= w_bs_new;
      end
      if ((r_state == S_RUN) && (r_phase == '0)) begin
        r_req <= !MREQ_n || !IORQ_n;
      end
      r_rdy      <= (r_state == S_RUN) && (r_rdy || RDY);
      r_term_n   <= (w_state_nxt != S_TERM);
      r_cc_n     <= ~w_phase_nxt;
      r_cx_n     <= !w_ext_nxt;
      r_wait_act <= (w_state_nxt == S_WAIT);
    end
  end

  assign TERM_n   = r_term_n;
  assign CC_n     = r_cc_n;
  assign CX_n     = r_cx_n;
  assign WAIT_ACT = r_wait_act;
  assign TMO      = r_tmo;
  assign LEN      = r_len;

endmodule

// File: tb/tb_cyc_ctl_gen.sv
// tb/tb_cyc_ctl_gen.sv - self-checking bench for cyc_ctl_gen with a cycle-level reference model
module tb_cyc_ctl_gen;

  localparam int CC_W       = 4;
  localparam int DLY_W      = 2;
  localparam int BASE_LEN   = 4;
  localparam int SHORT_LEN  = 3;
  localparam int SLOW_EXTRA = 2;
  localparam int TMO_W      = 4;
  localparam int TMO_LIMIT  = (1 << TMO_W) - 1;
  localparam int CC_MAX     = (1 << CC_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_TERM = 3;

  logic             sysclk = 1'b0;
  logic             sys_rst_n;
  logic             RUN;
  logic [DLY_W-1:0] CSDELAY;
  logic             SHORT_n;
  logic             SLOW_n;
  logic             MREQ_n;
  logic             IORQ_n;
  logic             RDY;
  logic             TRAP_n;
  logic             TERM_n;
  logic [CC_W-1:0]  CC_n;
  logic             CX_n;
  logic             WAIT_ACT;
  logic             TMO;
  logic [CC_W-1:0]  LEN;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: where we are within the current microcycle.
  int m_mode;
  int m_pos;
  int m_L;
  int m_bs;
  int m_wcnt;
  bit m_req;
  bit m_rdy;
  bit m_tmo;

  cyc_ctl_gen #(
    .CC_W(CC_W), .DLY_W(DLY_W), .BASE_LEN(BASE_LEN), .SHORT_LEN(SHORT_LEN),
    .SLOW_EXTRA(SLOW_EXTRA), .TMO_W(TMO_W)
  ) dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .RUN(RUN), .CSDELAY(CSDELAY),
    .SHORT_n(SHORT_n), .SLOW_n(SLOW_n), .MREQ_n(MREQ_n), .IORQ_n(IORQ_n),
    .RDY(RDY), .TRAP_n(TRAP_n), .TERM_n(TERM_n), .CC_n(CC_n), .CX_n(CX_n),
    .WAIT_ACT(WAIT_ACT), .TMO(TMO), .LEN(LEN)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_L = BASE_LEN; m_bs = BASE_LEN;
    m_wcnt = 0; m_req = 0; m_rdy = 0; m_tmo = 0;
  endtask

  // Applies the cycle rules to the inputs present at the clock edge.
  task automatic model_edge();
    int bs;
    bs = (SHORT_n ? BASE_LEN : SHORT_LEN) + (SLOW_n ? 0 : SLOW_EXTRA);
    m_tmo = 0;
    case (m_mode)
      M_IDLE: if (RUN) begin
        m_L = bs + int'(CSDELAY); m_bs = bs; m_mode = M_RUN; m_pos = 0; m_rdy = 0;
      end
      M_TERM: begin
        m_L = bs + int'(CSDELAY); m_bs = bs; m_pos = 0; m_rdy = 0;
        m_mode = RUN ? M_RUN : M_IDLE;
      end
      M_RUN: begin
        if (!TRAP_n) m_mode = M_TERM;
        else begin
          if (m_pos == 0) m_req = !MREQ_n || !IORQ_n;
          if (RDY) m_rdy = 1;
          if (m_pos == m_L - 2) begin
            if (m_req && !m_rdy) begin m_mode = M_WAIT; m_wcnt = 0; end
            else m_mode = M_TERM;
          end else m_pos++;
        end
      end
      default: begin
        if (!TRAP_n || RDY || m_wcnt == TMO_LIMIT) m_mode = M_TERM;
        else begin
          m_wcnt++;
          if (m_wcnt == TMO_LIMIT) m_tmo = 1;
        end
      end
    endcase
  endtask

  task automatic check_model();
    int ph;
    bit ext;
    ph  = (m_mode == M_TERM) ? m_L - 1 : (m_mode == M_WAIT) ? m_L - 2 : (m_mode == M_RUN) ? m_pos : 0;
    ext = (m_mode == M_WAIT) || ((m_mode == M_RUN || m_mode == M_TERM) && ph >= m_bs);
    check("term_n",   TERM_n,   (m_mode == M_TERM) ? 0 : 1);
    check("cc_n",     CC_n,     CC_MAX - ph);
    check("cx_n",     CX_n,     ext ? 0 : 1);
    check("wait_act", WAIT_ACT, (m_mode == M_WAIT) ? 1 : 0);
    check("tmo",      TMO,      m_tmo);
    check("len",      LEN,      m_L);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_term_n"}, TERM_n, 1);
    check({tag, "_cc_n"}, CC_n, CC_MAX);
    check({tag, "_cx_n"}, CX_n, 1);
    check({tag, "_wait_act"}, WAIT_ACT, 0);
    check({tag, "_tmo"}, TMO, 0);
    check({tag, "_len"}, LEN, BASE_LEN);
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic run_to_wait(input string tag);
    int k;
    k = 0;
    while (m_mode != M_WAIT && k < 30) begin tick(); k++; end
    check({tag, "_reached_wait"}, (m_mode == M_WAIT) ? 1 : 0, 1);
  endtask

  initial begin
    int n_wait;
    int n_tmo;
    int k;
    int rdy_pct;

    sys_rst_n = 1'b0; RUN = 1'b0; CSDELAY = '0; SHORT_n = 1'b1; SLOW_n = 1'b1;
    MREQ_n = 1'b1; IORQ_n = 1'b1; RDY = 1'b0; TRAP_n = 1'b1;
    model_reset();
    #12;
    check_reset_vals("reset");
    #1 sys_rst_n = 1'b1;

    // Default cycling: length 4, no extension.
    RUN = 1'b1;
    repeat (14) tick();

    // Memory request held off by RDY for five wait clocks.
    MREQ_n = 1'b0;
    run_to_wait("mreq");
    MREQ_n = 1'b1;
    n_wait = 1;
    check("mreq_cc_held", CC_n, 4'hD);
    repeat (4) begin tick(); if (WAIT_ACT === 1'b1) n_wait++; end
    RDY = 1'b1;
    tick();
    RDY = 1'b0;
    check("mreq_wait_clocks", n_wait, 5);
    check("mreq_term_after_rdy", TERM_n, 0);

    // IO request with no RDY: forced completion by the timeout.
    IORQ_n = 1'b0;
    run_to_wait("iorq");
    IORQ_n = 1'b1;
    n_wait = 1; n_tmo = (TMO === 1'b1) ? 1 : 0; k = 0;
    while (WAIT_ACT === 1'b1 && k < 40) begin
      tick(); k++;
      if (WAIT_ACT === 1'b1) n_wait++;
      if (TMO === 1'b1) n_tmo++;
    end
    check("tmo_wait_clocks", n_wait, TMO_LIMIT + 1);
    check("tmo_pulses", n_tmo, 1);
    check("tmo_then_term", TERM_n, 0);

    // Short cycle, then a slow cycle with three delay phases.
    SHORT_n = 1'b0;
    repeat (6) tick();
    SHORT_n = 1'b1; SLOW_n = 1'b0; CSDELAY = 2'd3;
    repeat (22) tick();

    // Trap at phase 1 of a 9-clock cycle.
    k = 0;
    while (!(m_mode == M_RUN && m_pos == 1 && m_L == 9) && k < 30) begin tick(); k++; end
    check("trap_reached_phase1", CC_n, 4'hE);
    TRAP_n = 1'b0;
    tick();
    TRAP_n = 1'b1;
    check("trap_term", TERM_n, 0);
    tick();
    check("trap_new_phase0", CC_n, 4'hF);
    check("trap_no_tmo", TMO, 0);

    // Reset pulsed during a wait.
    SLOW_n = 1'b1; CSDELAY = '0; MREQ_n = 1'b0;
    run_to_wait("rst");
    MREQ_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge sysclk);
    @(posedge sysclk);
    #3 sys_rst_n = 1'b1;
    k = 0;
    while (TERM_n !== 1'b0 && k < 10) begin tick(); k++; end
    check("rst_first_term_edges", k, 4);

    // Randomised operation, alternating RDY-rich and RDY-starved stretches.
    for (int blk = 0; blk < 12; blk++) begin
      rdy_pct = blk[0] ? 50 : 3;
      for (int i = 0; i < 200; i++) begin
        RUN     = ($urandom % 16) != 0;
        TRAP_n  = ($urandom % 40) != 0;
        RDY     = ($urandom % 100) < rdy_pct;
        MREQ_n  = ($urandom % 3) != 0;
        IORQ_n  = ($urandom % 3) != 0;
        SHORT_n = ($urandom % 2) != 0;
        SLOW_n  = ($urandom % 2) != 0;
        CSDELAY = DLY_W'($urandom);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
